// File: rtl/uart_mmio_ctrl_if.sv
// MMIO + serializer bus bundle for uart_mmio_ctrl.
// slave: the controller. master: the MMIO decode / serializer side.
interface uart_mmio_ctrl_if;
    logic        en;
    logic [3:0]  we;
    logic [7:0]  addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_strobe;
    logic        irq;

    modport slave (
        input  en, we, addr, din, tx_ready, rx_data, rx_strobe,
        output dout, tx_data, tx_valid, irq
    );

    modport master (
        output en, we, addr, din, tx_ready, rx_data, rx_strobe,
        input  dout, tx_data, tx_valid, irq
    );
endinterface

// File: rtl/uart_mmio_ctrl.sv
// uart_mmio_ctrl: MMIO front end for a UART.
//   0x00 STATUS (R) / sticky flag clear (W)
//   0x04 RXDATA (R, pops)
//   0x08 TXDATA (W, pushes)
//   0x0C IRQ_EN (R/W) only when UART_CTRL_IRQ_EN is defined;
//        otherwise reads 0, writes ignored and irq is tied low.
module uart_mmio_ctrl #(
    parameter int TX_DEPTH = 8,
    parameter int RX_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    uart_mmio_ctrl_if.slave bus
);
    localparam int TXAW = $clog2(TX_DEPTH);
    localparam int RXAW = $clog2(RX_DEPTH);
    localparam int TXCW = TXAW + 1;
    localparam int RXCW = RXAW + 1;

    // ---------------- MMIO decode ----------------
    logic rd_acc, wr_acc;
    logic tx_push_req, rx_pop_req, stat_wr;
    logic irq_en_wr;

    assign rd_acc      = bus.en && (bus.we == 4'b0000);
    assign wr_acc      = bus.en && bus.we[0];
    assign stat_wr     = wr_acc && (bus.addr == 8'h00);
    assign rx_pop_req  = rd_acc && (bus.addr == 8'h04);
    assign tx_push_req = wr_acc && (bus.addr == 8'h08);
    assign irq_en_wr   = wr_acc && (bus.addr == 8'h0C);

    // ---------------- TX FIFO ----------------
    logic [TX_DEPTH-1:0][7:0] tx_mem_q;
    logic [TXAW-1:0]          tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [TXCW-1:0]          tx_cnt_q, tx_cnt_d;
    logic                     tx_full, tx_empty, tx_push, tx_pop;

    assign tx_full  = (tx_cnt_q == TXCW'(TX_DEPTH));
    assign tx_empty = (tx_cnt_q == '0);
    // Full is judged on pre-edge occupancy, so a same-cycle drain does not
    // rescue a write to a full FIFO.
    assign tx_push  = tx_push_req && !tx_full;
    assign tx_pop   = !tx_empty && bus.tx_ready;

    // TX pointer/occupancy next state
    always_comb begin
        tx_wptr_d = tx_wptr_q;
        tx_rptr_d = tx_rptr_q;
        tx_cnt_d  = tx_cnt_q;
        if (tx_push) tx_wptr_d = tx_wptr_q + TXAW'(1);
        if (tx_pop)  tx_rptr_d = tx_rptr_q + TXAW'(1);
        tx_cnt_d = tx_cnt_q + TXCW'(tx_push) - TXCW'(tx_pop);
    end

    // TX FIFO storage and pointers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_mem_q  <= '0;
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
            tx_cnt_q  <= '0;
        end else begin
            if (tx_push) tx_mem_q[tx_wptr_q] <= bus.din[7:0];
            tx_wptr_q <= tx_wptr_d;
            tx_rptr_q <= tx_rptr_d;
            tx_cnt_q  <= tx_cnt_d;
        end
    end

    assign bus.tx_valid = !tx_empty;
    // Gate the head so stale storage never shows while idle.
    assign bus.tx_data  = tx_empty ? 8'h00 : tx_mem_q[tx_rptr_q];

    // ---------------- RX FIFO ----------------
    logic [RX_DEPTH-1:0][7:0] rx_mem_q;
    logic [RXAW-1:0]          rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [RXCW-1:0]          rx_cnt_q, rx_cnt_d;
    logic                     rx_full, rx_empty, rx_push, rx_pop;
    logic [7:0]               rx_head;

    assign rx_full  = (rx_cnt_q == RXCW'(RX_DEPTH));
    assign rx_empty = (rx_cnt_q == '0);
    assign rx_push  = bus.rx_strobe && !rx_full;
    assign rx_pop   = rx_pop_req && !rx_empty;
    assign rx_head  = rx_empty ? 8'h00 : rx_mem_q[rx_rptr_q];

    // RX pointer/occupancy next state
    always_comb begin
        rx_wptr_d = rx_wptr_q;
        rx_rptr_d = rx_rptr_q;
        rx_cnt_d  = rx_cnt_q;
        if (rx_push) rx_wptr_d = rx_wptr_q + RXAW'(1);
        if (rx_pop)  rx_rptr_d = rx_rptr_q + RXAW'(1);
        rx_cnt_d = rx_cnt_q + RXCW'(rx_push) - RXCW'(rx_pop);
    end

    // RX FIFO storage and pointers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_mem_q  <= '0;
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
            rx_cnt_q  <= '0;
        end else begin
            if (rx_push) rx_mem_q[rx_wptr_q] <= bus.rx_data;
            rx_wptr_q <= rx_wptr_d;
            rx_rptr_q <= rx_rptr_d;
            rx_cnt_q  <= rx_cnt_d;
        end
    end

    // ---------------- sticky flags ----------------
    logic rx_ovr_q, rx_ovr_d, tx_ovf_q, tx_ovf_d;

    // Set terms are ORed last so a same-cycle set beats a clear.
    always_comb begin
        rx_ovr_d = (rx_ovr_q && !(stat_wr && bus.din[2])) || (bus.rx_strobe && rx_full);
        tx_ovf_d = (tx_ovf_q && !(stat_wr && bus.din[4])) || (tx_push_req && tx_full);
    end

    // Sticky flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_ovr_q <= 1'b0;
            tx_ovf_q <= 1'b0;
        end else begin
            rx_ovr_q <= rx_ovr_d;
            tx_ovf_q <= tx_ovf_d;
        end
    end

    // ---------------- interrupt ----------------
    logic [31:0] irq_en_rd;
`ifdef UART_CTRL_IRQ_EN
    logic [1:0] irq_en_q;
    logic       irq_q, irq_d;

    assign irq_d = (irq_en_q[0] && !rx_empty) || (irq_en_q[1] && tx_empty);

    // IRQ enable register and registered interrupt (one cycle behind state)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_en_q <= 2'b00;
            irq_q    <= 1'b0;
        end else begin
            if (irq_en_wr) irq_en_q <= bus.din[1:0];
            irq_q <= irq_d;
        end
    end

    assign bus.irq   = irq_q;
    assign irq_en_rd = {30'b0, irq_en_q};
`else
    assign bus.irq   = 1'b0;
    assign irq_en_rd = 32'h0;
`endif

    // ---------------- read mux ----------------
    logic [31:0] status;
    assign status = {27'b0, tx_ovf_q, tx_empty, rx_ovr_q, !rx_empty, !tx_full};

    // Combinational read data; unmapped or deselected reads return 0
    always_comb begin
        bus.dout = 32'h0;
        if (bus.en) begin
            case (bus.addr)
                8'h00:   bus.dout = status;
                8'h04:   bus.dout = {24'b0, rx_head};
                8'h0C:   bus.dout = irq_en_rd;
                default: bus.dout = 32'h0;
            endcase
        end
    end

    // Bits with no function in this block, collected to keep lint quiet.
    logic unused_bits;
    assign unused_bits = ^{bus.din[31:8], bus.din[3], bus.din[1:0], bus.we[3:1], irq_en_wr};

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Self-checking bench for uart_mmio_ctrl (TX_DEPTH=8, RX_DEPTH=4).
module tb_uart_mmio_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_mmio_ctrl_if bus_if();

    uart_mmio_ctrl #(.TX_DEPTH(8), .RX_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int total = 0;
    int bad   = 0;
    logic [7:0] txq[$];
    logic [7:0] rxq[$];

    // ---- bus drivers (no checking) ----
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic mmio_wr(input logic [7:0] a, input logic [31:0] d);
        bus_if.en = 1'b1; bus_if.we = 4'h1; bus_if.addr = a; bus_if.din = d;
        step();
        bus_if.en = 1'b0; bus_if.we = 4'h0; bus_if.din = 32'h0;
    endtask

    task automatic mmio_rd(input logic [7:0] a, output logic [31:0] d);
        bus_if.en = 1'b1; bus_if.we = 4'h0; bus_if.addr = a;
        @(negedge clk); d = bus_if.dout;
        step();
        bus_if.en = 1'b0;
    endtask

    task automatic rx_push(input logic [7:0] b);
        bus_if.rx_strobe = 1'b1; bus_if.rx_data = b;
        step();
        bus_if.rx_strobe = 1'b0;
    endtask

    // ---- scenarios ----
    task automatic test_reset();
        logic [31:0] rd;
        rst = 1'b1;
        #2;
        total++; if (bus_if.tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid got=%b exp=0", bus_if.tx_valid); end
        total++; if (bus_if.tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data got=%h exp=00", bus_if.tx_data); end
        total++; if (bus_if.irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", bus_if.irq); end
        #20 rst = 1'b0;
        step();
        mmio_rd(8'h00, rd);
        total++; if (rd !== 32'h9) begin bad++; $display("FAIL reset_status got=%h exp=00000009", rd); end
    endtask

    task automatic test_tx_overflow();
        logic [31:0] rd;
        bus_if.tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            mmio_wr(8'h08, 32'h41 + i);
            txq.push_back(8'(8'h41 + i));
        end
        mmio_wr(8'h08, 32'h49); // full: dropped, not in the scoreboard
        mmio_rd(8'h00, rd);
        total++; if (rd !== 32'h10) begin bad++; $display("FAIL tx_full_status got=%h exp=00000010", rd); end
        bus_if.tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [7:0] exp;
            @(negedge clk);
            exp = (txq.size() != 0) ? txq.pop_front() : 8'hxx;
            total++;
            if (bus_if.tx_valid !== 1'b1 || bus_if.tx_data !== exp) begin
                bad++; $display("FAIL tx_drain[%0d] got valid=%b data=%h exp data=%h", i, bus_if.tx_valid, bus_if.tx_data, exp);
            end
            step();
        end
        @(negedge clk);
        total++; if (bus_if.tx_valid !== 1'b0) begin bad++; $display("FAIL tx_drain_end got valid=%b data=%h exp valid=0", bus_if.tx_valid, bus_if.tx_data); end
        step();
        bus_if.tx_ready = 1'b0;
        mmio_rd(8'h00, rd);
        total++; if (rd !== 32'h19) begin bad++; $display("FAIL tx_idle_status got=%h exp=00000019", rd); end
    endtask

    task automatic test_rx_overrun();
        logic [31:0] rd;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) rxq.push_back(8'(8'h10 + i));
            rx_push(8'(8'h10 + i));
        end
        mmio_rd(8'h00, rd);
        total++; if (rd !== 32'h1F) begin bad++; $display("FAIL rx_overrun_status got=%h exp=0000001f", rd); end
        for (int i = 0; i < 4; i++) begin
            logic [7:0] exp;
            exp = rxq.pop_front();
            mmio_rd(8'h04, rd);
            total++; if (rd !== {24'b0, exp}) begin bad++; $display("FAIL rx_read[%0d] got=%h exp=%h", i, rd, exp); end
        end
        mmio_rd(8'h04, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL rx_read_empty got=%h exp=0", rd); end
        mmio_rd(8'h00, rd);
        total++; if (rd !== 32'h1D) begin bad++; $display("FAIL rx_empty_status got=%h exp=0000001d", rd); end
    endtask

    task automatic test_flag_clear();
        logic [31:0] rd;
        mmio_wr(8'h00, 32'h14);
        mmio_rd(8'h00, rd);
        total++; if (rd !== 32'h09) begin bad++; $display("FAIL flag_clear got=%h exp=00000009", rd); end
    endtask

    task automatic test_rx_same_cycle();
        logic [31:0] rd;
        logic [7:0]  exp;
        for (int i = 0; i < 4; i++) begin
            rxq.push_back(8'(8'h20 + i));
            rx_push(8'(8'h20 + i));
        end
        // full FIFO: strobe and pop together; strobed byte must be dropped
        bus_if.en = 1'b1; bus_if.we = 4'h0; bus_if.addr = 8'h04;
        bus_if.rx_strobe = 1'b1; bus_if.rx_data = 8'h99;
        @(negedge clk); rd = bus_if.dout;
        step();
        bus_if.en = 1'b0; bus_if.rx_strobe = 1'b0;
        exp = rxq.pop_front();
        total++; if (rd !== {24'b0, exp}) begin bad++; $display("FAIL same_cycle_read got=%h exp=%h", rd, exp); end
        mmio_rd(8'h00, rd);
        total++; if (rd !== 32'h0F) begin bad++; $display("FAIL same_cycle_status got=%h exp=0000000f", rd); end
        for (int i = 0; i < 3; i++) begin
            exp = rxq.pop_front();
            mmio_rd(8'h04, rd);
            total++; if (rd !== {24'b0, exp}) begin bad++; $display("FAIL same_cycle_rest[%0d] got=%h exp=%h", i, rd, exp); end
        end
        mmio_rd(8'h04, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL same_cycle_dropped got=%h exp=0", rd); end
    endtask

    task automatic test_set_wins();
        logic [31:0] rd;
        mmio_wr(8'h00, 32'h04);
        mmio_rd(8'h00, rd);
        total++; if (rd !== 32'h09) begin bad++; $display("FAIL set_wins_pre got=%h exp=00000009", rd); end
        for (int i = 0; i < 4; i++) begin
            rxq.push_back(8'(8'h30 + i));
            rx_push(8'(8'h30 + i));
        end
        bus_if.en = 1'b1; bus_if.we = 4'h1; bus_if.addr = 8'h00; bus_if.din = 32'h04;
        bus_if.rx_strobe = 1'b1; bus_if.rx_data = 8'h77;
        step();
        bus_if.en = 1'b0; bus_if.we = 4'h0; bus_if.din = 32'h0; bus_if.rx_strobe = 1'b0;
        mmio_rd(8'h00, rd);
        total++; if (rd !== 32'h0F) begin bad++; $display("FAIL set_wins got=%h exp=0000000f", rd); end
        mmio_wr(8'h00, 32'h04);
        mmio_rd(8'h00, rd);
        total++; if (rd !== 32'h0B) begin bad++; $display("FAIL set_wins_clear got=%h exp=0000000b", rd); end
        for (int i = 0; i < 4; i++) begin
            logic [7:0] exp;
            exp = rxq.pop_front();
            mmio_rd(8'h04, rd);
            total++; if (rd !== {24'b0, exp}) begin bad++; $display("FAIL set_wins_drain[%0d] got=%h exp=%h", i, rd, exp); end
        end
    endtask

    task automatic test_back_to_back();
        bus_if.tx_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                bus_if.en = 1'b1; bus_if.we = 4'h1; bus_if.addr = 8'h08; bus_if.din = 32'h60 + i;
            end else begin
                bus_if.en = 1'b0; bus_if.we = 4'h0;
            end
            @(negedge clk);
            if (i == 0) begin
                total++; if (bus_if.tx_valid !== 1'b0) begin bad++; $display("FAIL b2b_latency got valid=%b exp=0", bus_if.tx_valid); end
            end else begin
                logic [7:0] exp;
                exp = txq.pop_front();
                total++;
                if (bus_if.tx_valid !== 1'b1 || bus_if.tx_data !== exp) begin
                    bad++; $display("FAIL b2b[%0d] got valid=%b data=%h exp data=%h", i, bus_if.tx_valid, bus_if.tx_data, exp);
                end
            end
            if (i < 4) txq.push_back(8'(8'h60 + i));
            step();
        end
        bus_if.din = 32'h0;
        @(negedge clk);
        total++; if (bus_if.tx_valid !== 1'b0) begin bad++; $display("FAIL b2b_end got valid=%b exp=0", bus_if.tx_valid); end
        step();
        bus_if.tx_ready = 1'b0;
    endtask

    task automatic test_irq();
        logic [31:0] rd;
`ifdef UART_CTRL_IRQ_EN
        bit seen;
        mmio_wr(8'h0C, 32'h1);
        mmio_rd(8'h0C, rd);
        total++; if (rd !== 32'h1) begin bad++; $display("FAIL irq_en_read got=%h exp=1", rd); end
        rxq.push_back(8'h55);
        rx_push(8'h55);
        seen = 1'b0;
        for (int k = 0; k < 2 && !seen; k++) begin
            @(negedge clk);
            if (bus_if.irq === 1'b1) seen = 1'b1;
            step();
        end
        total++; if (!seen) begin bad++; $display("FAIL irq_rise got=0 exp=1 within 2 cycles"); end
        mmio_rd(8'h04, rd);
        total++; if (rd !== {24'b0, rxq[0]}) begin bad++; $display("FAIL irq_rx_read got=%h exp=%h", rd, rxq[0]); end
        void'(rxq.pop_front());
        step();
        @(negedge clk);
        total++; if (bus_if.irq !== 1'b0) begin bad++; $display("FAIL irq_fall got=%b exp=0", bus_if.irq); end
        step();
        mmio_wr(8'h0C, 32'h0);
`else
        mmio_wr(8'h0C, 32'h3);
        mmio_rd(8'h0C, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL irq_en_absent got=%h exp=0", rd); end
        rxq.push_back(8'h55);
        rx_push(8'h55);
        step();
        @(negedge clk);
        total++; if (bus_if.irq !== 1'b0) begin bad++; $display("FAIL irq_tied got=%b exp=0", bus_if.irq); end
        step();
        mmio_rd(8'h04, rd);
        total++; if (rd !== {24'b0, rxq[0]}) begin bad++; $display("FAIL irq_rx_read got=%h exp=%h", rd, rxq[0]); end
        void'(rxq.pop_front());
`endif
    endtask

    task automatic test_reset_mid_drain();
        logic [31:0] rd;
        bus_if.tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) mmio_wr(8'h08, 32'h71 + i);
        bus_if.tx_ready = 1'b1;
        @(negedge clk);
        total++; if (bus_if.tx_data !== 8'h71) begin bad++; $display("FAIL mid_drain_head got=%h exp=71", bus_if.tx_data); end
        #1 rst = 1'b1;
        #1;
        total++; if (bus_if.tx_valid !== 1'b0 || bus_if.tx_data !== 8'h00) begin
            bad++; $display("FAIL mid_drain_reset got valid=%b data=%h exp valid=0 data=00", bus_if.tx_valid, bus_if.tx_data);
        end
        #10 rst = 1'b0;
        step();
        bus_if.tx_ready = 1'b0;
        mmio_rd(8'h00, rd);
        total++; if (rd !== 32'h9) begin bad++; $display("FAIL mid_drain_status got=%h exp=00000009", rd); end
    endtask

    initial begin
        bus_if.en = 1'b0; bus_if.we = 4'h0; bus_if.addr = 8'h00; bus_if.din = 32'h0;
        bus_if.tx_ready = 1'b0; bus_if.rx_data = 8'h00; bus_if.rx_strobe = 1'b0;
        test_reset();
        test_tx_overflow();
        test_rx_overrun();
        test_flag_clear();
        test_rx_same_cycle();
        test_set_wins();
        test_back_to_back();
        test_irq();
        test_reset_mid_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
